// File: rtl/csr_io_pkg.sv
// Shared definitions for the CSR-mapped I/O bank.
//   csr_op_e     : CSR operation encoding carried on csr_op
//   DefaultBase  : CSR address of input channel 0 unless overridden
//   out_offset() : offset of the OUT region from BASE
//   edge_offset(): offset of the EDGE region from BASE
package csr_io_pkg;

    typedef enum logic [1:0] {
        CsrRead  = 2'd0,
        CsrWrite = 2'd1,
        CsrSet   = 2'd2,
        CsrClear = 2'd3
    } csr_op_e;

    localparam logic [11:0] DefaultBase = 12'hF00;

    // OUT channels follow directly after the IN channels.
    function automatic logic [11:0] out_offset(input int unsigned n_in);
        return 12'(n_in);
    endfunction

    // EDGE flag registers follow directly after the OUT channels.
    function automatic logic [11:0] edge_offset(input int unsigned n_in,
                                                input int unsigned n_out);
        return 12'(n_in + n_out);
    endfunction

endpackage

// File: rtl/csr_io_bank_io_sync.sv
// Per-bit flop-chain synchroniser for one input channel.
//   clk    : clock
//   rst_n  : synchronous active-low reset, clears every stage
//   data_i : asynchronous input word
//   data_o : synchronised word, STAGES cycles after the first sampling edge
module io_sync #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = data_i;
        for (int s = 1; s < STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign data_o = stage_q[STAGES-1];

endmodule

// File: rtl/csr_io_bank.sv
// CSR-mapped I/O bank: N_IN synchronised inputs, N_OUT output registers and
// sticky per-input rising-edge flags with a combined interrupt.
//   clk, rst_n : clock, synchronous active-low reset
//   csr_valid  : one request per asserted cycle
//   csr_addr   : CSR address; IN at BASE+i, OUT at BASE+N_IN+j,
//                EDGE at BASE+N_IN+N_OUT+i
//   csr_op     : READ / WRITE / SET / CLEAR (csr_op_e)
//   csr_wdata  : write data or bit mask
//   csr_rdata  : registered read data (value before the request took effect)
//   csr_hit    : registered, request decoded to this bank
//   io_in      : asynchronous inputs, channel i at [i*WIDTH +: WIDTH]
//   io_out     : output registers, channel j at [j*WIDTH +: WIDTH]
//   edge_irq   : registered OR of all edge flags
module csr_io_bank
    import csr_io_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned N_IN        = 2,
    parameter int unsigned N_OUT       = 2,
    parameter logic [11:0] BASE        = DefaultBase,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   csr_valid,
    input  logic [11:0]            csr_addr,
    input  logic [1:0]             csr_op,
    input  logic [WIDTH-1:0]       csr_wdata,
    output logic [WIDTH-1:0]       csr_rdata,
    output logic                   csr_hit,
    input  logic [N_IN*WIDTH-1:0]  io_in,
    output logic [N_OUT*WIDTH-1:0] io_out,
    output logic                   edge_irq
);

    localparam logic [11:0] OutLo  = out_offset(N_IN);
    localparam logic [11:0] EdgeLo = edge_offset(N_IN, N_OUT);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] in_sync [N_IN];

    for (genvar i = 0; i < N_IN; i++) begin : gen_sync
        io_sync #(
            .WIDTH  (WIDTH),
            .STAGES (SYNC_STAGES)
        ) u_io_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .data_i (io_in[i*WIDTH +: WIDTH]),
            .data_o (in_sync[i])
        );
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    csr_op_e     op;
    logic [11:0] addr_off;
    logic        addr_ge_base;
    logic [N_IN-1:0]  in_sel;
    logic [N_OUT-1:0] out_sel;
    logic [N_IN-1:0]  edge_sel;

    assign op           = csr_op_e'(csr_op);
    // Addresses below BASE would wrap in 12-bit arithmetic; exclude them first.
    assign addr_ge_base = (csr_addr >= BASE);
    assign addr_off     = csr_addr - BASE;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            in_sel[i]   = csr_valid && addr_ge_base && (addr_off == 12'(i));
            edge_sel[i] = csr_valid && addr_ge_base && (addr_off == EdgeLo + 12'(i));
        end
        for (int j = 0; j < N_OUT; j++) begin
            out_sel[j] = csr_valid && addr_ge_base && (addr_off == OutLo + 12'(j));
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_q     [N_OUT];
    logic [WIDTH-1:0] out_d     [N_OUT];
    logic [WIDTH-1:0] edge_q    [N_IN];
    logic [WIDTH-1:0] edge_d    [N_IN];
    logic [WIDTH-1:0] in_prev_q [N_IN];
    logic [WIDTH-1:0] in_prev_d [N_IN];
    logic [WIDTH-1:0] rise      [N_IN];
    logic [WIDTH-1:0] clr_mask  [N_IN];
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             hit_q, hit_d;
    logic             irq_q, irq_d;

    // Edge detection and write-1-to-clear masks.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            rise[i]      = in_sync[i] & ~in_prev_q[i];
            in_prev_d[i] = in_sync[i];
            clr_mask[i]  = '0;
            if (edge_sel[i] && ((op == CsrWrite) || (op == CsrClear))) begin
                clr_mask[i] = csr_wdata;
            end
            // A rise in the same cycle as a clear keeps the flag set.
            edge_d[i] = (edge_q[i] & ~clr_mask[i]) | rise[i];
        end
    end

    // Output register updates.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            out_d[j] = out_q[j];
            if (out_sel[j]) begin
                unique case (op)
                    CsrWrite: out_d[j] = csr_wdata;
                    CsrSet:   out_d[j] = out_q[j] | csr_wdata;
                    CsrClear: out_d[j] = out_q[j] & ~csr_wdata;
                    default:  out_d[j] = out_q[j];
                endcase
            end
        end
    end

    // Read mux: always returns the pre-request value of the addressed register.
    always_comb begin
        rdata_d = '0;
        hit_d   = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_sel[i]) begin
                hit_d   = 1'b1;
                rdata_d = in_sync[i];
            end
            if (edge_sel[i]) begin
                hit_d   = 1'b1;
                rdata_d = edge_q[i];
            end
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (out_sel[j]) begin
                hit_d   = 1'b1;
                rdata_d = out_q[j];
            end
        end
    end

    // Interrupt follows the flags by one cycle.
    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            irq_d = irq_d | (|edge_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                out_q[j] <= '0;
            end
            for (int i = 0; i < N_IN; i++) begin
                edge_q[i]    <= '0;
                in_prev_q[i] <= '0;
            end
            rdata_q <= '0;
            hit_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                out_q[j] <= out_d[j];
            end
            for (int i = 0; i < N_IN; i++) begin
                edge_q[i]    <= edge_d[i];
                in_prev_q[i] <= in_prev_d[i];
            end
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            irq_q   <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar j = 0; j < N_OUT; j++) begin : gen_out
        assign io_out[j*WIDTH +: WIDTH] = out_q[j];
    end

    assign csr_rdata = rdata_q;
    assign csr_hit   = hit_q;
    assign edge_irq  = irq_q;

endmodule

// File: tb/tb_csr_io_bank.sv
// Self-checking bench for csr_io_bank: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural model of the bank.
module tb_csr_io_bank;

    localparam int          W    = 32;
    localparam int          NI   = 2;
    localparam int          NO   = 2;
    localparam int          SYNC = 2;
    localparam logic [11:0] BASE = 12'hF00;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              csr_valid = 1'b0;
    logic [11:0]       csr_addr = '0;
    logic [1:0]        csr_op = '0;
    logic [W-1:0]      csr_wdata = '0;
    logic [W-1:0]      csr_rdata;
    logic              csr_hit;
    logic [NI*W-1:0]   io_in = '0;
    logic [NO*W-1:0]   io_out;
    logic              edge_irq;

    csr_io_bank #(
        .WIDTH       (W),
        .N_IN        (NI),
        .N_OUT       (NO),
        .BASE        (BASE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .csr_valid (csr_valid),
        .csr_addr  (csr_addr),
        .csr_op    (csr_op),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_hit   (csr_hit),
        .io_in     (io_in),
        .io_out    (io_out),
        .edge_irq  (edge_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [W-1:0]    out_m  [NO];
    logic [W-1:0]    flag_m [NI];
    logic [NI*W-1:0] prev_m;
    logic [NI*W-1:0] pipe [$];  // io_in samples, oldest = value seen by reads
    logic [W-1:0]    exp_rdata;
    logic            exp_hit;
    logic            exp_irq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NO; j++) out_m[j] = '0;
        for (int i = 0; i < NI; i++) flag_m[i] = '0;
        prev_m = '0;
        pipe.delete();
        for (int s = 0; s < SYNC; s++) pipe.push_back('0);
        exp_rdata = '0;
        exp_hit   = 1'b0;
        exp_irq   = 1'b0;
    endtask

    // Predict the effect of the coming clock edge, take it, then compare.
    task automatic tick();
        logic [NI*W-1:0] sync_now;
        logic [W-1:0]    clr [NI];
        logic [NO*W-1:0] exp_out;
        int              off;
        if (!rst_n) begin
            model_reset();
        end else begin
            sync_now  = pipe[0];
            exp_hit   = 1'b0;
            exp_rdata = '0;
            exp_irq   = 1'b0;
            for (int i = 0; i < NI; i++) begin
                clr[i]  = '0;
                exp_irq = exp_irq | (flag_m[i] != 0);
            end
            if (csr_valid && (csr_addr >= BASE)) begin
                off = int'(csr_addr) - int'(BASE);
                if (off < NI) begin
                    exp_hit   = 1'b1;
                    exp_rdata = sync_now[off*W +: W];
                end else if (off < NI + NO) begin
                    exp_hit   = 1'b1;
                    exp_rdata = out_m[off-NI];
                    case (csr_op)
                        2'd1: out_m[off-NI] = csr_wdata;
                        2'd2: out_m[off-NI] = out_m[off-NI] | csr_wdata;
                        2'd3: out_m[off-NI] = out_m[off-NI] & ~csr_wdata;
                        default: ;
                    endcase
                end else if (off < 2*NI + NO) begin
                    exp_hit   = 1'b1;
                    exp_rdata = flag_m[off-NI-NO];
                    if (csr_op == 2'd1 || csr_op == 2'd3) clr[off-NI-NO] = csr_wdata;
                end
            end
            for (int i = 0; i < NI; i++) begin
                flag_m[i] = (flag_m[i] & ~clr[i])
                          | (sync_now[i*W +: W] & ~prev_m[i*W +: W]);
            end
            prev_m = sync_now;
            void'(pipe.pop_front());
            pipe.push_back(io_in);
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < NO; j++) exp_out[j*W +: W] = out_m[j];
        check("csr_hit", 64'(csr_hit), 64'(exp_hit));
        check("csr_rdata", 64'(csr_rdata), 64'(exp_rdata));
        check("io_out", 64'(io_out), 64'(exp_out));
        check("edge_irq", 64'(edge_irq), 64'(exp_irq));
    endtask

    task automatic req(input logic v, input logic [11:0] a, input logic [1:0] op,
                       input logic [W-1:0] wd);
        csr_valid = v;
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = wd;
        tick();
        csr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) req(1'b0, 12'h000, 2'd0, '0);
    endtask

    logic [NO*W-1:0] saved_out;

    initial begin
        model_reset();

        // Reset and IN read.
        rst_n = 1'b0;
        idle(2);
        check("reset_io_out", 64'(io_out), 64'h0);
        check("reset_hit", 64'(csr_hit), 64'h0);
        rst_n = 1'b1;
        io_in[31:0] = 32'hDEADBEEF;
        idle(SYNC + 1);
        req(1'b1, 12'hF00, 2'd0, '0);
        check("in0_read_hit", 64'(csr_hit), 64'h1);
        check("in0_read_data", 64'(csr_rdata), 64'hDEADBEEF);

        // OUT ops on channel 0.
        req(1'b1, 12'hF02, 2'd1, 32'h0000_00F0);
        check("out0_write", 64'(io_out[31:0]), 64'hF0);
        req(1'b1, 12'hF02, 2'd2, 32'h0000_000F);
        check("out0_set_rdata", 64'(csr_rdata), 64'hF0);
        check("out0_set", 64'(io_out[31:0]), 64'hFF);
        req(1'b1, 12'hF02, 2'd3, 32'h0000_00F0);
        check("out0_clear_rdata", 64'(csr_rdata), 64'hFF);
        check("out0_clear", 64'(io_out[31:0]), 64'h0F);
        req(1'b1, 12'hF02, 2'd0, '0);
        check("out0_read", 64'(csr_rdata), 64'h0F);

        // Edge capture on ch1 bit3 and write-1-to-clear.
        req(1'b1, 12'hF04, 2'd1, 32'hFFFF_FFFF);
        idle(1);
        io_in[63:32] = 32'h8;
        idle(SYNC + 2);
        check("edge_irq_set", 64'(edge_irq), 64'h1);
        req(1'b1, 12'hF05, 2'd0, '0);
        check("edge1_flag", 64'(csr_rdata), 64'h8);
        req(1'b1, 12'hF05, 2'd1, 32'h8);
        idle(1);
        check("edge_irq_clear", 64'(edge_irq), 64'h0);

        // Clear lands on the same edge as a fresh synchronised rise.
        io_in[63:32] = 32'h0;
        idle(SYNC + 2);
        io_in[63:32] = 32'h8;
        idle(SYNC);
        req(1'b1, 12'hF05, 2'd1, 32'h8);
        req(1'b1, 12'hF05, 2'd0, '0);
        check("edge_collision", 64'(csr_rdata), 64'h8);

        // Unmapped and read-only.
        req(1'b1, 12'hF06, 2'd0, '0);
        check("unmapped_hi_hit", 64'(csr_hit), 64'h0);
        check("unmapped_hi_data", 64'(csr_rdata), 64'h0);
        req(1'b1, 12'hEFF, 2'd0, '0);
        check("unmapped_lo_hit", 64'(csr_hit), 64'h0);
        check("unmapped_lo_data", 64'(csr_rdata), 64'h0);
        saved_out = io_out;
        req(1'b1, 12'hF00, 2'd1, 32'h1234_5678);
        check("in_write_hit", 64'(csr_hit), 64'h1);
        check("in_write_out", 64'(io_out), 64'(saved_out));
        req(1'b1, 12'hF00, 2'd0, '0);
        check("in_after_write", 64'(csr_rdata), 64'hDEADBEEF);

        // Reset coinciding with a write to OUT1.
        rst_n = 1'b0;
        req(1'b1, 12'hF03, 2'd1, 32'h1234);
        check("rst_mid_out1", 64'(io_out[63:32]), 64'h0);
        check("rst_mid_hit", 64'(csr_hit), 64'h0);
        rst_n = 1'b1;
        idle(1);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) io_in = {$urandom(), $urandom()};
            rst_n = ($urandom_range(0, 49) != 0);
            req($urandom_range(0, 3) != 0,
                ($urandom_range(0, 4) != 0) ? 12'hF00 + 12'($urandom_range(0, 7))
                                           : 12'($urandom()),
                2'($urandom()),
                ($urandom_range(0, 1) == 0) ? $urandom() : (32'h1 << $urandom_range(0, 31)));
        end
        rst_n = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csr_io_bank.md
# csr_io_bank

Parametrised CSR-mapped I/O bank that replaces the core's hard-wired two-input/two-output GPIO decode. It has N_IN synchronised input ports, N_OUT output registers, and per-input sticky rising-edge capture with an interrupt line. The bank sits on the core's CSR path. Requests come from the execute stage, and read data returns one cycle later, aligned with writeback.

## Interface
- WIDTH, 32, bits per channel
- N_IN, 2, input channels (1..16)
- N_OUT, 2, output channels (1..16)
- BASE, 12'hF00, CSR address of input channel 0
- SYNC_STAGES, 2, flops per input synchroniser (>=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- csr_valid  in  1  request strobe, one request per asserted cycle
- csr_addr  in  12  CSR address
- csr_op  in  2  0=READ, 1=WRITE, 2=SET, 3=CLEAR
- csr_wdata  in  WIDTH  write/mask operand
- csr_rdata  out  WIDTH  read data, registered
- csr_hit  out  1  registered, address decoded to this bank
- io_in  in  N_IN*WIDTH  asynchronous inputs, channel i at [i*WIDTH +: WIDTH]
- io_out  out  N_OUT*WIDTH  output registers, channel j at [j*WIDTH +: WIDTH]
- edge_irq  out  1  OR of all edge flags, registered

## Operation
- Address map:
  - IN[i] = BASE+i, read-only, synchronised sample.
  - OUT[j] = BASE+N_IN+j, read/write.
  - EDGE[i] = BASE+N_IN+N_OUT+i, sticky rising-edge flags.
- Reads of a mapped address return the value held before the request takes effect (CSR read-then-modify semantics), for every op.
- OUT ops:
  - WRITE: reg=wdata.
  - SET: reg|=wdata.
  - CLEAR: reg&=~wdata.
  - READ: no change.
- IN ops: WRITE, SET and CLEAR are ignored. Data is still returned and csr_hit=1.
- EDGE ops:
  - WRITE and CLEAR clear the bits that are 1 in wdata (write-1-to-clear).
  - SET is ignored.
  - READ: no change.
- Edge detect: a flag bit sets when the synchronised bit is 1 and its previous synchronised value was 0.
- Simultaneous edge and clear on the same bit: set wins, so the flag stays 1.
- Unmapped address: csr_hit=0, csr_rdata=0, no state change.
- csr_valid=0: csr_hit=0 and csr_rdata=0 next cycle, no state change.

## Timing
- Request sampled at edge E. csr_rdata and csr_hit are valid in the cycle after E and held for exactly one cycle.
- OUT update is registered at E, so io_out reflects it in the cycle after E.
- Back-to-back requests are supported every cycle. A read of OUT[j] in the cycle after a write to OUT[j] returns the new value.
- Input latency: an io_in change is visible on IN[i] reads SYNC_STAGES cycles after the first sampling edge. An edge flag sets one cycle after the synchronised rise. edge_irq follows one cycle after that.
- Reset (synchronous, any cycle, including mid-request): all io_out=0, all edge flags=0, edge_irq=0, csr_rdata=0, csr_hit=0, synchroniser and previous-value flops=0.
  - A request sampled in the reset cycle is dropped.
  - An input held at 1 through reset produces one edge flag after release. This is intended.

## Structure
- Package csr_io_pkg:
  - csr_op_e enum (READ/WRITE/SET/CLEAR).
  - Default BASE constant.
  - Localparam functions for the OUT and EDGE region offsets.
- Sub-module io_sync: parameter WIDTH and STAGES, a per-bit flop chain with synchronous reset. Instantiated N_IN times.
- Decode is combinational from csr_addr-BASE, with a range check against each region. Widths are compared in 12-bit unsigned arithmetic; an address below BASE is unmapped.

## Test plan
- Reset and IN read: reset, drive io_in ch0=32'hDEADBEEF, wait SYNC_STAGES+1 cycles, READ 12'hF00 -> next cycle csr_hit=1, csr_rdata=32'hDEADBEEF; all io_out=0 after reset.
- OUT ops: WRITE OUT0 (12'hF02) 32'h0000_00F0, then SET 32'h0F, then CLEAR 32'hF0 -> io_out ch0 sequence F0, FF, 0F; reads return F0, FF, 0F on following cycles; the SET request itself returns F0.
- Edge capture: io_in ch1 bit3 0->1 -> EDGE1 (12'hF05) bit3=1 and edge_irq=1. WRITE 32'h8 -> flag cleared, edge_irq=0 one cycle later.
- Edge and clear collision: time a clear of bit3 so it lands in the same cycle as a new synchronised rise -> flag remains 1.
- Unmapped and read-only: READ 12'hF06 and 12'hEFF -> csr_hit=0, csr_rdata=0. WRITE to 12'hF00 -> IN unchanged, io_out unchanged.
- Reset mid-operation: assert rst_n=0 in the same cycle as a WRITE OUT1 32'h1234 -> io_out ch1 stays 0, csr_hit=0 next cycle.
